// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: stage-register state encoding and the NOP word
// used as the bubble value for instruction fields.
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter for performance debug; holds at all-ones instead
// of wrapping, cleared only by reset.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready inter-stage register with flush and optional 2-entry
// skid buffer (registered in_ready), plus a saturating stall counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned    W          = 32,
  parameter int unsigned    SKID       = 1,
  parameter logic [W-1:0]   BUBBLE_VAL = {W{1'b0}},
  parameter int unsigned    CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam bit SKID_EN = (SKID != 0);

  state_t       state_p1, state_d;
  logic [W-1:0] main_p1, main_d;
  logic [W-1:0] skid_p1, skid_d;
  logic         ready_p1;
  logic         in_fire, out_fire;
  logic         stall_inc;

  assign out_valid = (state_p1 != ST_EMPTY);
  assign out_data  = main_p1;
  assign occupancy = state_p1;

  // Skid mode breaks the out_ready -> in_ready path with a register.
  assign in_ready = SKID_EN ? ready_p1 : (~out_valid | out_ready);

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d = state_p1;
    main_d  = main_p1;
    skid_d  = skid_p1;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
    end else begin
      case (state_p1)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_BUSY;
            main_d  = in_data;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire && SKID_EN) begin
            // Downstream stalled while a new word arrived: park it behind main.
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE_VAL;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d = ST_BUSY;
            main_d  = skid_p1;
            skid_d  = BUBBLE_VAL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE_VAL;
          skid_d  = BUBBLE_VAL;
        end
      endcase
    end
  end

  // Stage p1: held entries and registered upstream ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p1 <= ST_EMPTY;
      main_p1  <= BUBBLE_VAL;
      skid_p1  <= BUBBLE_VAL;
      ready_p1 <= 1'b1;
    end else begin
      state_p1 <= state_d;
      main_p1  <= main_d;
      skid_p1  <= skid_d;
      ready_p1 <= (state_d != ST_FULL);
    end
  end

  assign stall_inc = out_valid & ~out_ready & ~flush;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised successor to the fixed-field inter-stage registers (F/D, D/E, E/M, M/W).
- Carries one packed payload word between two pipeline stages using a valid/ready handshake, with flush (bubble insertion) and an optional 2-entry skid mode that registers the upstream ready.
- Also provides a saturating stall-cycle counter for performance debug.
- The fixed-field stage registers are replaced by instances of this block, with fields packed into DATA.

Parameters:
- W, 32, payload width in bits (≥1).
- SKID, 1, 0 = single register with combinational in_ready; 1 = main + skid register with registered in_ready.
- BUBBLE_VAL, {W{1'b0}}, value driven on out_data whenever no valid entry is held (NOP encoding, 0 for MIPS IR).
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  discard all held entries this cycle.
- in_valid  in  1  upstream presents a payload.
- in_data  in  W  upstream payload.
- in_ready  out  1  stage can accept a payload this cycle.
- out_valid  out  1  stage holds a valid payload.
- out_data  out  W  payload to the downstream stage.
- out_ready  in  1  downstream accepts out_data this cycle.
- occupancy  out  2  number of held entries (0..2).
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (asynchronous, immediate):
  - State EMPTY; main and skid registers = BUBBLE_VAL.
  - out_valid=0, out_data=BUBBLE_VAL, occupancy=0, stall_cnt=0.
  - in_ready=1 after reset deasserts (SKID=1: registered ready resets to 1).
  - Reset mid-transfer loses all held entries.
- Latency: 1 cycle in_fire → out_valid when the stage is empty; throughput 1 item per cycle when out_ready is held high.
- States: EMPTY (occ 0), BUSY (main valid, occ 1), FULL (main+skid valid, occ 2; SKID=1 only).
- SKID=0:
  - in_ready = ~out_valid | out_ready (combinational).
  - EMPTY: in_fire → BUSY, main ← in_data.
  - BUSY: in_fire → stay BUSY, main ← in_data (out_fire is implied).
  - BUSY: out_fire & ~in_fire → EMPTY, main ← BUBBLE_VAL.
- SKID=1:
  - in_ready is a register: 1 unless the next state is FULL. No combinational path from out_ready to in_ready.
  - EMPTY: in_fire → BUSY, main ← in_data.
  - BUSY, in_fire & out_fire → BUSY, main ← in_data.
  - BUSY, in_fire & ~out_ready → FULL, skid ← in_data.
  - BUSY, out_fire & ~in_fire → EMPTY, main ← BUBBLE_VAL.
  - FULL: out_fire → BUSY, main ← skid, skid ← BUBBLE_VAL. in_ready=0, so no in_fire is possible.
- Ordering: FIFO order is preserved; the skid entry is never presented before main.
- out_valid = (state != EMPTY); out_data = main.
- flush:
  - Highest priority after reset. Next state is EMPTY; main and skid ← BUBBLE_VAL.
  - Any in_fire in the same cycle is discarded.
  - An out_fire in the same cycle still counts as delivered downstream.
  - SKID=1: in_ready is 1 in the following cycle.
- Held data stability: while out_valid & ~out_ready, out_data and out_valid do not change, except on flush or reset.
- stall_cnt:
  - Increments each cycle with out_valid & ~out_ready & ~flush.
  - Saturates at 2^CNT_W − 1; never wraps.
  - Cleared only by reset.
- Idle hold: with no in_valid, no out_ready and no flush, all state is held.

Decomposition:
- Shared pipeline package holds:
  - State encoding constants ST_EMPTY=2'd0, ST_BUSY=2'd1, ST_FULL=2'd2.
  - NOP_INSTR=32'h0000_0000, used as BUBBLE_VAL for instruction fields.
- One natural sub-module: sat_counter (parameter CNT_W; inputs inc, clk, reset; output count), also reused by other performance counters.
- Payload packing (IR, PC4, PC8, ALUout, DMout, RDst) is done by the instantiating stage, not in this block.

Test Plan:
- Reset/idle: assert reset mid-cycle with FULL held → out_valid=0, out_data=0, occupancy=0, stall_cnt=0 immediately; in_ready=1 after release.
- Streaming (SKID=1): out_ready=1, send 0x11,0x22,0x33 back-to-back → out_data 0x11,0x22,0x33 on consecutive cycles, each 1 cycle after input; occupancy never exceeds 1.
- Backpressure: send 0xA1,0xA2 with out_ready=0 → occupancy=2, in_ready=0, out_data holds 0xA1. Raise out_ready → 0xA1 then 0xA2 delivered in order; stall_cnt increases by the number of stalled cycles.
- Flush: FULL with 0xB1/0xB2, assert flush together with in_valid=1, in_data 0xB3 → next cycle out_valid=0, out_data=0, occupancy=0; 0xB3 never appears.
- SKID=0 path: out_valid=1, out_ready=0 → in_ready=0 in the same cycle. Toggle out_ready=1 → in_ready=1 combinationally, and the new data replaces the old in one cycle.
- Counter saturation: CNT_W=4, hold a stall for 20 cycles → stall_cnt=15 and remains 15.
